lcd_char_render: RTL and testbench

- Responder side of the character-display handshake. It consumes show_char_flag, ascii_num, start_x, start_y and en_size from the content controller, and returns one show_char_done pulse per finished character.
- Each glyph is rendered by setting the ST7735 window (CASET/RASET/RAMWR), then streaming RGB565 pixels built from font ROM rows as bytes to the SPI byte writer.
- Sits between the content controller, the external font ROM and the SPI byte writer.

---
 rtl/lcd_pkg.sv | 42 ++++
 rtl/lcd_win_seq.sv | 72 +++++++
 rtl/lcd_char_render.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_char_render.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared ST7735 command codes, font geometry and render FSM types
// for the character renderer.
package lcd_pkg;

  localparam logic [7:0] CASET = 8'h2A;
  localparam logic [7:0] RASET = 8'h2B;
  localparam logic [7:0] RAMWR = 8'h2C;

  localparam int W16 = 8;
  localparam int H16 = 16;
  localparam int W12 = 6;
  localparam int H12 = 12;

  typedef enum logic [2:0] {
    IDLE,
    WIN,
    ROW,
    PIX,
    DONE,
    SETTLE
  } state_e;

  typedef struct packed {
    logic       size;
    logic [6:0] ascii;
    logic [8:0] x;
    logic [8:0] y;
  } char_req_t;

  function automatic logic [11:0] font_addr_f(
    input logic        size,
    input logic [6:0]  ascii,
    input logic [4:0]  row,
    input logic [11:0] base
  );
    logic [11:0] a;
    a = {5'd0, ascii};
    if (size) return {1'b0, ascii, 4'd0} + {7'd0, row};
    return base + (a << 3) + (a << 2) + {7'd0, row};
  endfunction

endpackage

// File: rtl/lcd_win_seq.sv
// Emits the 11-byte CASET/RASET/RAMWR window sequence
// over a valid/ready byte port, then pulses done.
module lcd_win_seq
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [8:0] xs,
  input  logic [8:0] xe,
  input  logic [8:0] ys,
  input  logic [8:0] ye,
  input  logic       ready,
  output logic       valid,
  output logic       dc,
  output logic [7:0] data,
  output logic       done
);

  logic [3:0] idx_q, idx_d;
  logic       act_q, act_d;
  logic       done_q, done_d;

  always_comb begin
    idx_d  = idx_q;
    act_d  = act_q;
    done_d = 1'b0;
    if (start) begin
      act_d = 1'b1;
      idx_d = 4'd0;
    end else if (act_q && ready) begin
      if (idx_q == 4'd10) begin
        act_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  always_comb begin
    valid = act_q;
    done  = done_q;
    dc    = !(idx_q == 4'd0 || idx_q == 4'd5 || idx_q == 4'd10);
    unique case (idx_q)
      4'd0:    data = CASET;
      4'd1:    data = {7'd0, xs[8]};
      4'd2:    data = xs[7:0];
      4'd3:    data = {7'd0, xe[8]};
      4'd4:    data = xe[7:0];
      4'd5:    data = RASET;
      4'd6:    data = {7'd0, ys[8]};
      4'd7:    data = ys[7:0];
      4'd8:    data = {7'd0, ye[8]};
      4'd9:    data = ye[7:0];
      default: data = RAMWR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= 4'd0;
      act_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      act_q  <= act_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/lcd_char_render.sv
// Renders CHAR_NUM glyphs per start pulse: sets the panel window,
// then streams RGB565 pixels from font ROM rows to the SPI writer.
module lcd_char_render
  import lcd_pkg::*;
#(
  parameter int          CHAR_NUM    = 12,
  parameter int          SETTLE_CYC  = 3,
  parameter logic [8:0]  X_OFS       = 9'd2,
  parameter logic [8:0]  Y_OFS       = 9'd1,
  parameter logic [15:0] FG_COLOR    = 16'hFFFF,
  parameter logic [15:0] BG_COLOR    = 16'h0000,
  parameter logic [11:0] FONT12_BASE = 12'd1536
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        show_char_flag,
  input  logic        en_size,
  input  logic [6:0]  ascii_num,
  input  logic [8:0]  start_x,
  input  logic [8:0]  start_y,
  output logic        show_char_done,
  output logic        busy,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        wr_dc,
  output logic [7:0]  wr_data
);

  state_e      state_q, state_d;
  char_req_t   req_q, req_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  row_q, row_d;
  logic [2:0]  bit_q, bit_d;
  logic        lo_q, lo_d;
  logic        rd_q, rd_d;
  logic [1:0]  settle_q, settle_d;
  logic [7:0]  bits_q, bits_d;
  logic [11:0] addr_q, addr_d;

  logic        seq_start, seq_valid, seq_dc, seq_done;
  logic [7:0]  seq_data;
  logic [8:0]  xs, xe, ys, ye;
  logic [8:0]  w_m1, h_m1;
  logic [4:0]  h;
  logic [2:0]  bit_last;
  logic [15:0] color;
  char_req_t   req_in;

  assign req_in   = '{en_size, ascii_num, start_x, start_y};
  assign w_m1     = req_q.size ? 9'(W16 - 1) : 9'(W12 - 1);
  assign h_m1     = req_q.size ? 9'(H16 - 1) : 9'(H12 - 1);
  assign h        = req_q.size ? 5'(H16) : 5'(H12);
  assign bit_last = req_q.size ? 3'(8 - W16) : 3'(8 - W12);
  assign xs       = req_q.x + X_OFS;
  assign xe       = xs + w_m1;
  assign ys       = req_q.y + Y_OFS;
  assign ye       = ys + h_m1;
  assign color    = bits_q[bit_q] ? FG_COLOR : BG_COLOR;

  lcd_win_seq u_win (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .start (seq_start),
    .xs    (xs),
    .xe    (xe),
    .ys    (ys),
    .ye    (ye),
    .ready (wr_ready),
    .valid (seq_valid),
    .dc    (seq_dc),
    .data  (seq_data),
    .done  (seq_done)
  );

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    busy_d         = busy_q;
    cnt_d          = cnt_q;
    row_d          = row_q;
    bit_d          = bit_q;
    lo_d           = lo_q;
    rd_d           = rd_q;
    settle_d       = settle_q;
    bits_d         = bits_q;
    addr_d         = addr_q;
    seq_start      = 1'b0;
    wr_valid       = 1'b0;
    wr_dc          = 1'b0;
    wr_data        = 8'd0;
    show_char_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (show_char_flag) begin
          req_d     = req_in;
          busy_d    = 1'b1;
          seq_start = 1'b1;
          state_d   = WIN;
        end
      end
      WIN: begin
        wr_valid = seq_valid;
        wr_dc    = seq_dc;
        wr_data  = seq_data;
        if (seq_done) begin
          row_d   = 5'd0;
          rd_d    = 1'b0;
          state_d = ROW;
        end
      end
      ROW: begin
        // second cycle: ROM data for the address issued on entry
        if (rd_q) begin
          bits_d  = font_data;
          bit_d   = 3'd7;
          lo_d    = 1'b0;
          rd_d    = 1'b0;
          state_d = PIX;
        end else begin
          rd_d = 1'b1;
        end
      end
      PIX: begin
        wr_valid = 1'b1;
        wr_dc    = 1'b1;
        wr_data  = lo_q ? color[7:0] : color[15:8];
        if (wr_ready) begin
          lo_d = !lo_q;
          if (lo_q) begin
            if (bit_q == bit_last) begin
              row_d   = row_q + 5'd1;
              state_d = (row_d < h) ? ROW : DONE;
            end else begin
              bit_d = bit_q - 3'd1;
            end
          end
        end
      end
      DONE: begin
        show_char_done = 1'b1;
        if (cnt_q == 4'(CHAR_NUM - 1)) begin
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d    = cnt_q + 4'd1;
          settle_d = 2'd0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == 2'(SETTLE_CYC - 1)) begin
          req_d     = req_in;
          seq_start = 1'b1;
          state_d   = WIN;
        end else begin
          settle_d = settle_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == ROW && state_q != ROW) begin
      addr_d = font_addr_f(req_q.size, req_q.ascii, row_d, FONT12_BASE);
    end
  end

  assign busy      = busy_q;
  assign font_addr = addr_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      busy_q   <= 1'b0;
      cnt_q    <= 4'd0;
      row_q    <= 5'd0;
      bit_q    <= 3'd0;
      lo_q     <= 1'b0;
      rd_q     <= 1'b0;
      settle_q <= 2'd0;
      bits_q   <= 8'd0;
      addr_q   <= 12'd0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      bit_q    <= bit_d;
      lo_q     <= lo_d;
      rd_q     <= rd_d;
      settle_q <= settle_d;
      bits_q   <= bits_d;
      addr_q   <= addr_d;
    end
  end

endmodule

// File: tb/tb_lcd_char_render.sv
// Bench for lcd_char_render: byte-stream model, registered font ROM,
// controller stepping through a 12-entry coordinate table.
module tb_lcd_char_render;

  logic        sys_clk;
  logic        sys_rst;
  logic        show_char_flag;
  logic        en_size;
  logic [6:0]  ascii_num;
  logic [8:0]  start_x;
  logic [8:0]  start_y;
  logic        show_char_done;
  logic        busy;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_dc;
  logic [7:0]  wr_data;

  lcd_char_render dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .show_char_flag (show_char_flag),
    .en_size        (en_size),
    .ascii_num      (ascii_num),
    .start_x        (start_x),
    .start_y        (start_y),
    .show_char_done (show_char_done),
    .busy           (busy),
    .font_addr      (font_addr),
    .font_data      (font_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_dc          (wr_dc),
    .wr_data        (wr_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [8:0] b;
    bit         last;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] addr_q[$];
  logic [8:0]  log_q[$];
  logic [8:0]  ref_q[$];
  logic [11:0] addr_log[$];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  int tx[12];
  int ty[12];
  int ta[12];
  bit ts[12];

  function automatic logic [7:0] rom_f(input logic [11:0] a);
    logic [11:0] t;
    if (a == 12'd1280) return 8'hA0;
    t = a * 12'd37 + 12'd11;
    return t[7:0] ^ {4'd0, a[11:8]};
  endfunction

  always @(posedge sys_clk) font_data <= rom_f(font_addr);

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic pushb(input bit dc, input int v, input bit last);
    exp_t e;
    e.b    = {dc, 8'(v)};
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic push_char(input bit sz, input int asc, input int x, input int y);
    int w, h, xs, xe, ys, ye, a;
    logic [7:0] r;
    bit lst;
    w  = sz ? 8 : 6;
    h  = sz ? 16 : 12;
    xs = (x + 2) % 512;
    xe = (xs + w - 1) % 512;
    ys = (y + 1) % 512;
    ye = (ys + h - 1) % 512;
    pushb(0, 'h2A, 0);
    pushb(1, xs / 256, 0); pushb(1, xs % 256, 0);
    pushb(1, xe / 256, 0); pushb(1, xe % 256, 0);
    pushb(0, 'h2B, 0);
    pushb(1, ys / 256, 0); pushb(1, ys % 256, 0);
    pushb(1, ye / 256, 0); pushb(1, ye % 256, 0);
    pushb(0, 'h2C, 0);
    for (int row = 0; row < h; row++) begin
      a = sz ? asc * 16 + row : 1536 + asc * 12 + row;
      addr_q.push_back(12'(a));
      r = rom_f(12'(a));
      for (int col = 0; col < w; col++) begin
        lst = (row == h - 1) && (col == w - 1);
        pushb(1, r[7-col] ? 'hFF : 'h00, 0);
        pushb(1, r[7-col] ? 'hFF : 'h00, lst);
      end
    end
  endtask

  // Scoreboard: every cycle, away from the active edge
  logic       prev_stall;
  logic [8:0] prev_b;
  logic       done_pend;
  logic [11:0] last_addr;
  exp_t       ce;
  logic [11:0] ca;

  always @(negedge sys_clk) begin
    if (sys_rst || !chk_en) begin
      prev_stall = 1'b0;
      done_pend  = 1'b0;
      last_addr  = 12'd0;
    end else begin
      chk(show_char_done === done_pend, "done_pulse",
          32'(show_char_done), 32'(done_pend));
      done_pend = 1'b0;
      if (prev_stall)
        chk(wr_valid === 1'b1 && {wr_dc, wr_data} === prev_b, "stall_hold",
            32'({wr_valid, wr_dc, wr_data}), 32'({1'b1, prev_b}));
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "extra_byte", 32'({wr_dc, wr_data}), 32'h0);
        end else begin
          ce = exp_q.pop_front();
          chk({wr_dc, wr_data} === ce.b, "byte", 32'({wr_dc, wr_data}), 32'(ce.b));
          if (ce.last) done_pend = 1'b1;
        end
        log_q.push_back({wr_dc, wr_data});
      end
      prev_stall = wr_valid && !wr_ready;
      prev_b     = {wr_dc, wr_data};
      if (font_addr !== last_addr) begin
        addr_log.push_back(font_addr);
        if (addr_q.size() == 0) begin
          chk(1'b0, "extra_addr", 32'(font_addr), 32'h0);
        end else begin
          ca = addr_q.pop_front();
          chk(font_addr === ca, "font_addr", 32'(font_addr), 32'(ca));
        end
        last_addr = font_addr;
      end
    end
  end

  task automatic drive(input int k);
    en_size   = ts[k];
    ascii_num = 7'(ta[k]);
    start_x   = 9'(tx[k]);
    start_y   = 9'(ty[k]);
  endtask

  task automatic run_frame(input bit stall, input int rst_at, input int flag_at);
    int k;
    bit fin, tail;
    log_q.delete();
    addr_log.delete();
    exp_q.delete();
    addr_q.delete();
    for (int i = 0; i < 12; i++) push_char(ts[i], ta[i], tx[i], ty[i]);
    drive(0);
    k = 0;
    fin = 0;
    tail = 0;
    show_char_flag = 1'b1;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      wr_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (cyc == flag_at) show_char_flag = 1'b1;
      if (cyc == rst_at) begin
        sys_rst = 1'b1;
        exp_q.delete();
        addr_q.delete();
      end
      @(posedge sys_clk);
      #1;
      show_char_flag = 1'b0;
      if (sys_rst) begin
        chk(wr_valid === 1'b0, "rst_valid", 32'(wr_valid), 32'h0);
        chk(busy === 1'b0, "rst_busy", 32'(busy), 32'h0);
        chk(show_char_done === 1'b0, "rst_done", 32'(show_char_done), 32'h0);
        sys_rst = 1'b0;
        fin = 1;
      end else if (tail) begin
        chk(busy === 1'b0, "busy_fall", 32'(busy), 32'h0);
        fin = 1;
      end else if (show_char_done) begin
        k++;
        if (k < 12) drive(k);
        else tail = 1;
      end
    end
    chk(fin, "timeout", 32'(fin), 32'h1);
    if (rst_at < 0) chk(k == 12, "done_count", 32'(k), 32'd12);
    chk(exp_q.size() == 0 && addr_q.size() == 0, "model_drained",
        32'(exp_q.size()), 32'h0);
  endtask

  logic [8:0] win_lit[11];
  logic [8:0] pix_lit[10];
  bit         same;

  initial begin
    win_lit = '{9'h02A, 9'h100, 9'h122, 9'h100, 9'h129,
                9'h02B, 9'h100, 9'h111, 9'h100, 9'h120, 9'h02C};
    pix_lit = '{9'h1FF, 9'h1FF, 9'h100, 9'h100, 9'h1FF,
                9'h1FF, 9'h100, 9'h100, 9'h100, 9'h100};
    for (int k = 0; k < 12; k++) begin
      ts[k] = (k < 8);
      tx[k] = (k < 8) ? 32 + 8 * k : 8 + 8 * (k - 8);
      ty[k] = (k < 8) ? 16 : 48;
      ta[k] = 33 + k;
    end
    ta[0] = 80;
    ta[8] = 1;

    sys_rst        = 1'b1;
    show_char_flag = 1'b0;
    wr_ready       = 1'b0;
    drive(0);
    repeat (3) @(posedge sys_clk);
    #1;
    chk(wr_valid === 1'b0, "reset_wr_valid", 32'(wr_valid), 32'h0);
    chk(busy === 1'b0, "reset_busy", 32'(busy), 32'h0);
    chk(show_char_done === 1'b0, "reset_done", 32'(show_char_done), 32'h0);
    chk(font_addr === 12'd0, "reset_font_addr", 32'(font_addr), 32'h0);
    chk(wr_dc === 1'b0, "reset_wr_dc", 32'(wr_dc), 32'h0);
    chk(wr_data === 8'd0, "reset_wr_data", 32'(wr_data), 32'h0);
    sys_rst = 1'b0;
    chk_en  = 1'b1;

    run_frame(1'b0, -1, -1);
    chk(log_q.size() == 2756, "total_bytes", 32'(log_q.size()), 32'd2756);
    for (int i = 0; i < 11; i++)
      chk(log_q[i] === win_lit[i], "win_literal", 32'(log_q[i]), 32'(win_lit[i]));
    for (int i = 0; i < 10; i++)
      chk(log_q[11+i] === pix_lit[i], "pix_literal",
          32'(log_q[11+i]), 32'(pix_lit[i]));
    chk(log_q[2136+4] === 9'h10F, "xe_12x6", 32'(log_q[2136+4]), 32'h10F);
    chk(log_q[2136+9] === 9'h13C, "ye_12x6", 32'(log_q[2136+9]), 32'h13C);
    chk(addr_log[0] === 12'd1280, "addr_first", 32'(addr_log[0]), 32'd1280);
    chk(addr_log[15] === 12'd1295, "addr_last", 32'(addr_log[15]), 32'd1295);
    chk(addr_log[128] === 12'd1548, "addr_12x6", 32'(addr_log[128]), 32'd1548);
    ref_q = log_q;

    run_frame(1'b1, -1, 200);
    same = (log_q.size() == ref_q.size());
    if (same)
      for (int i = 0; i < ref_q.size(); i++)
        if (log_q[i] !== ref_q[i]) same = 0;
    chk(same, "stall_stream", 32'(log_q.size()), 32'(ref_q.size()));
    wr_ready = 1'b1;
    repeat (20) @(posedge sys_clk);
    #1;
    chk(wr_valid === 1'b0 && busy === 1'b0, "flag_ignored",
        32'({wr_valid, busy}), 32'h0);

    run_frame(1'b0, 40, -1);
    repeat (2) @(posedge sys_clk);
    #1;
    run_frame(1'b0, -1, -1);
    for (int i = 0; i < 11; i++)
      chk(log_q[i] === win_lit[i], "restart_literal",
          32'(log_q[i]), 32'(win_lit[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
